// File: rtl/usbls_crc_engine.sv
// usbls_crc_engine: bit-serial USB CRC5/CRC16 engine for the low-speed host datapath.
// Words are consumed LSB first, one bit per bit_en cycle. The final complemented CRC is
// given in parallel, together with a good-residual flag for RX packet checking.
// Optional feature: define USBLS_CRC_APPEND_EN to add an APPEND state that shifts the
// complemented CRC out serially on tx_bit/tx_bit_valid after the last data bit.

module usbls_crc_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              start,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_last,
  output logic [15:0]       crc_out,
  output logic              crc_valid,
  output logic              crc_ok,
  output logic              busy,
  output logic              tx_bit,
  output logic              tx_bit_valid
);

  localparam logic [15:0] Poly16 = 16'hA001;
  localparam logic [4:0]  Poly5  = 5'h14;
  localparam logic [15:0] Res16  = 16'hB001;
  localparam logic [4:0]  Res5   = 5'h06;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StAccept = 3'd1,
    StShift  = 3'd2,
`ifdef USBLS_CRC_APPEND_EN
    StAppend = 3'd4,
`endif
    StDone   = 3'd3
  } state_e;

  // Reflected CRC update for one data bit; CRC5 lives in [4:0] with [15:5] kept zero.
  function automatic logic [15:0] crc_step(input logic [15:0] r, input logic d,
                                           input logic m);
    logic [15:0] n;
    if (m) begin
      n = r >> 1;
      if (d ^ r[0]) n = n ^ Poly16;
    end else begin
      n = {12'd0, r[4:1]};
      if (d ^ r[0]) n[4:0] = n[4:0] ^ Poly5;
    end
    return n;
  endfunction

  function automatic logic [15:0] crc_preset(input logic m);
    return m ? 16'hFFFF : 16'h001F;
  endfunction

  function automatic logic [15:0] crc_final(input logic [15:0] r, input logic m);
    return m ? ~r : {11'd0, ~r[4:0]};
  endfunction

  function automatic logic crc_good(input logic [15:0] r, input logic m);
    return m ? (r == Res16) : (r[4:0] == Res5);
  endfunction

  state_e              state_q, state_d;
  logic [15:0]         crc_q, crc_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                last_q, last_d;
  logic [15:0]         crc_out_q, crc_out_d;
  logic                crc_ok_q, crc_ok_d;
  logic [15:0]         crc_next;
  logic                shift_done;
`ifdef USBLS_CRC_APPEND_EN
  logic [15:0]         tx_sr_q, tx_sr_d;
  logic [4:0]          app_cnt_q, app_cnt_d;
  logic                app_last;

  assign app_last = (app_cnt_q == (mode_q ? 5'd15 : 5'd4));
`endif

  // Data word is shifted right as it is consumed, so bit 0 is always the next bit.
  assign crc_next   = crc_step(crc_q, data_q[0], mode_q);
  assign shift_done = (cnt_q == len_q - LEN_W'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; start overrides everything, including DONE
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StAccept;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StIdle;
        StAccept: if (in_valid) state_d = StShift;
        StShift: begin
          if (bit_en && shift_done) begin
            if (!last_q) state_d = StAccept;
`ifdef USBLS_CRC_APPEND_EN
            else         state_d = StAppend;
`else
            else         state_d = StDone;
`endif
          end
        end
`ifdef USBLS_CRC_APPEND_EN
        StAppend: if (bit_en && app_last) state_d = StDone;
`endif
        StDone:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Datapath next-state: CRC register, captured word, bit counter, result latches
  always_comb begin
    crc_d     = crc_q;
    mode_d    = mode_q;
    data_d    = data_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    crc_out_d = crc_out_q;
    crc_ok_d  = crc_ok_q;
`ifdef USBLS_CRC_APPEND_EN
    tx_sr_d   = tx_sr_q;
    app_cnt_d = app_cnt_q;
`endif
    if (start) begin
      mode_d    = mode;
      crc_d     = crc_preset(mode);
      crc_out_d = '0;
      crc_ok_d  = 1'b0;
      cnt_d     = '0;
      last_d    = 1'b0;
    end else begin
      unique case (state_q)
        StAccept: begin
          if (in_valid) begin
            data_d = in_data;
            len_d  = (in_len == '0) ? LEN_W'(DATA_W) : in_len;
            last_d = in_last;
            cnt_d  = '0;
          end
        end
        StShift: begin
          if (bit_en) begin
            crc_d  = crc_next;
            data_d = data_q >> 1;
            cnt_d  = cnt_q + LEN_W'(1);
            if (shift_done && last_q) begin
`ifdef USBLS_CRC_APPEND_EN
              tx_sr_d   = crc_final(crc_next, mode_q);
              app_cnt_d = '0;
`else
              crc_out_d = crc_final(crc_next, mode_q);
              crc_ok_d  = crc_good(crc_next, mode_q);
`endif
            end
          end
        end
`ifdef USBLS_CRC_APPEND_EN
        // CRC register is frozen here; only the serial copy shifts
        StAppend: begin
          if (bit_en) begin
            tx_sr_d   = tx_sr_q >> 1;
            app_cnt_d = app_cnt_q + 5'd1;
            if (app_last) begin
              crc_out_d = crc_final(crc_q, mode_q);
              crc_ok_d  = crc_good(crc_q, mode_q);
            end
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q     <= 16'hFFFF;
      mode_q    <= 1'b0;
      data_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      crc_out_q <= '0;
      crc_ok_q  <= 1'b0;
`ifdef USBLS_CRC_APPEND_EN
      tx_sr_q   <= '0;
      app_cnt_q <= '0;
`endif
    end else begin
      crc_q     <= crc_d;
      mode_q    <= mode_d;
      data_q    <= data_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      crc_out_q <= crc_out_d;
      crc_ok_q  <= crc_ok_d;
`ifdef USBLS_CRC_APPEND_EN
      tx_sr_q   <= tx_sr_d;
      app_cnt_q <= app_cnt_d;
`endif
    end
  end

  // Outputs decoded from state and result latches
  always_comb begin
    in_ready     = (state_q == StAccept);
    crc_valid    = (state_q == StDone);
    busy         = (state_q != StIdle);
    crc_out      = crc_out_q;
    crc_ok       = crc_ok_q;
`ifdef USBLS_CRC_APPEND_EN
    tx_bit       = (state_q == StAppend) & tx_sr_q[0];
    tx_bit_valid = (state_q == StAppend) & bit_en;
`else
    tx_bit       = 1'b0;
    tx_bit_valid = 1'b0;
`endif
  end

endmodule

// File: tb/tb_usbls_crc_engine.sv
// Table-driven bench for usbls_crc_engine: directed packet vectors with hand-computed
// CRCs, plus sequences for abort, start-in-DONE and asynchronous reset mid-packet.
// Checks tx_bit output when USBLS_CRC_APPEND_EN is defined.

module tb_usbls_crc_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_en;
  logic        start;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [3:0]  in_len;
  logic        in_last;
  logic [15:0] crc_out;
  logic        crc_valid;
  logic        crc_ok;
  logic        busy;
  logic        tx_bit;
  logic        tx_bit_valid;

  always #5 clk = ~clk;

  usbls_crc_engine #(.DATA_W(8), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_len(in_len),
    .in_last(in_last), .crc_out(crc_out), .crc_valid(crc_valid), .crc_ok(crc_ok),
    .busy(busy), .tx_bit(tx_bit), .tx_bit_valid(tx_bit_valid)
  );

  typedef struct {
    logic             mode;
    int               nw;
    logic [15:0][7:0] data;
    logic [15:0][3:0] len;
    logic             thr;
    logic             chk_crc;
    logic [15:0]      exp_crc;
    logic             exp_ok;
  } vec_t;

  vec_t        vecs [7];
  int          total = 0;
  int          bad = 0;
  int          valid_cnt = 0;
  int          ready_cnt = 0;
  int          tx_cnt = 0;
  logic [15:0] cap_crc = '0;
  logic        cap_ok = 1'b0;
  logic [15:0] tx_hist = '0;
  logic        throttle = 1'b0;
  int          cyc = 0;

  function automatic vec_t mk(input logic m, input int nw, input logic [127:0] d,
                              input logic [63:0] l, input logic thr, input logic cc,
                              input logic [15:0] crc, input logic ok);
    vec_t v;
    v.mode = m; v.nw = nw; v.data = d; v.len = l; v.thr = thr;
    v.chk_crc = cc; v.exp_crc = crc; v.exp_ok = ok;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Bit strobe: full rate, or one cycle in eight when throttled
  initial begin
    bit_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bit_en = throttle ? (cyc % 8 == 0) : 1'b1;
    end
  end

  // Monitor: count result pulses, ready cycles and serial CRC bits
  always @(negedge clk) begin
    if (crc_valid) begin
      valid_cnt <= valid_cnt + 1;
      cap_crc   <= crc_out;
      cap_ok    <= crc_ok;
    end
    if (in_ready) ready_cnt <= ready_cnt + 1;
    if (tx_bit_valid) begin
      tx_cnt  <= tx_cnt + 1;
      tx_hist <= {tx_bit, tx_hist[15:1]};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic start_pkt(input logic m, input logic thr);
    @(posedge clk); #1;
    throttle = thr;
    start = 1'b1;
    mode = m;
    @(posedge clk); #1;
    start = 1'b0;
    mode = ~m;  // must be ignored until the next start
  endtask

  task automatic feed(input vec_t v, input string tag);
    for (int w = 0; w < v.nw; w++) begin
      int n;
      n = 0;
      in_data  = v.data[w];
      in_len   = v.len[w];
      in_last  = (w == v.nw - 1);
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        chk({tag, "_ready_timeout"}, 32'(in_ready), 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t  v;
    int    v0, r0, t0, n, k;
    string tag;
    v   = vecs[idx];
    tag = $sformatf("vec%0d", idx);
    k   = v.mode ? 16 : 5;
    start_pkt(v.mode, v.thr);
    v0 = valid_cnt; r0 = ready_cnt; t0 = tx_cnt;
    chk({tag, "_ok_clr"}, 32'(crc_ok), 0);
    chk({tag, "_out_clr"}, 32'(crc_out), 0);
    chk({tag, "_busy"}, 32'(busy), 1);
    feed(v, tag);
    n = 0;
    while (valid_cnt == v0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid_seen"}, 32'(valid_cnt - v0), 1);
    repeat (3) @(negedge clk);
    chk({tag, "_one_pulse"}, 32'(valid_cnt - v0), 1);
    if (v.chk_crc) begin
      chk({tag, "_crc"}, 32'(cap_crc), 32'(v.exp_crc));
      chk({tag, "_crc_hold"}, 32'(crc_out), 32'(v.exp_crc));
    end
    chk({tag, "_ok"}, 32'(cap_ok), 32'(v.exp_ok));
    chk({tag, "_ok_hold"}, 32'(crc_ok), 32'(v.exp_ok));
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_ready_cycles"}, 32'(ready_cnt - r0), 32'(v.nw));
`ifdef USBLS_CRC_APPEND_EN
    chk({tag, "_tx_count"}, 32'(tx_cnt - t0), 32'(k));
    if (v.chk_crc) chk({tag, "_tx_bits"}, 32'(tx_hist >> (16 - k)), 32'(v.exp_crc));
`else
    chk({tag, "_tx_count"}, 32'(tx_cnt - t0), 0);
`endif
    throttle = 1'b0;
  endtask

  initial begin
    int n, v0;
    rst = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0;
    in_data = '0; in_len = '0; in_last = 1'b0;

    // {mode, words, bytes (byte0 in LSBs), lens (nibble0 in LSBs), throttle, check crc, crc, ok}
    vecs[0] = mk(1'b0, 2, 128'h0101, 64'h38, 1'b0, 1'b1, 16'h0018, 1'b0);  // token addr1 endp2
    vecs[1] = mk(1'b0, 2, 128'hC101, 64'h88, 1'b0, 1'b1, 16'h0019, 1'b1);  // token + CRC5 bits
    vecs[2] = mk(1'b1, 9, 128'h393837363534333231, 64'h888888888, 1'b0, 1'b1, 16'hB4C8, 1'b0);
    vecs[3] = mk(1'b1, 2, 128'h0000, 64'h88, 1'b0, 1'b1, 16'h4FFE, 1'b1);  // empty DATA0 CRC
    vecs[4] = mk(1'b1, 2, 128'h0001, 64'h88, 1'b0, 1'b0, 16'h0000, 1'b0);  // one bit flipped
    vecs[5] = mk(1'b1, 9, 128'h393837363534333231, 64'h0, 1'b0, 1'b1, 16'hB4C8, 1'b0);
    vecs[6] = mk(1'b1, 9, 128'h393837363534333231, 64'h888888888, 1'b1, 1'b1, 16'hB4C8, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_crc_valid", 32'(crc_valid), 0);
    chk("rst_crc_ok", 32'(crc_ok), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_bit", 32'(tx_bit), 0);
    chk("rst_tx_valid", 32'(tx_bit_valid), 0);
    chk("rst_crc_out", 32'(crc_out), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Abort mid-SHIFT: the aborted last word must never produce crc_valid
    v0 = valid_cnt;
    start_pkt(1'b1, 1'b0);
    in_data = 8'h31; in_len = 4'd8; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_ready_low", 32'(in_ready), 0);
    chk("abort_busy", 32'(busy), 1);
    run_vec(2);
    chk("abort_pulses", 32'(valid_cnt - v0), 1);

    // start while in DONE: crc_valid still pulses, then ACCEPT with crc_ok cleared
    v0 = valid_cnt;
    start_pkt(1'b0, 1'b0);
    feed(vecs[1], "sdone");
    n = 0;
    while (!crc_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sdone_valid", 32'(crc_valid), 1);
    chk("sdone_ok", 32'(crc_ok), 1);
    chk("sdone_crc", 32'(crc_out), 32'h19);
    start = 1'b1;
    mode  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("sdone_accept", 32'(in_ready), 1);
    chk("sdone_busy", 32'(busy), 1);
    chk("sdone_ok_clr", 32'(crc_ok), 0);
    chk("sdone_valid_end", 32'(crc_valid), 0);
    chk("sdone_pulses", 32'(valid_cnt - v0), 1);

    // Asynchronous reset mid-packet
    start_pkt(1'b1, 1'b0);
    in_data = 8'h31; in_len = 4'd8; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #3;
    chk("arst_busy_before", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_crc_valid", 32'(crc_valid), 0);
    chk("arst_crc_ok", 32'(crc_ok), 0);
    chk("arst_crc_out", 32'(crc_out), 0);
    chk("arst_tx_valid", 32'(tx_bit_valid), 0);
    v0 = valid_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("arst_no_valid", 32'(valid_cnt - v0), 0);
    run_vec(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
